// File: rtl/dreg_share_arbiter.sv
// dreg_share_arbiter: round-robin arbiter sharing one registered data word among requesters
module dreg_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  localparam int OW = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [OW-1:0]         owner,
  output logic                  err
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t        r_state;
  logic [OW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] w_win;
  logic          w_any;
  int            w_j;
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_any && req[w_j]) begin
        w_any = 1'b1;
        w_win = OW'(w_j);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (r_state == IDLE) begin
        if (w_any) begin
          gnt     <= NREQ'(1) << w_win;
          q       <= wdata[int'(w_win)*WIDTH +: WIDTH];
          owner   <= w_win;
          q_valid <= 1'b1;
          r_ptr   <= (w_win == OW'(NREQ-1)) ? '0 : w_win + 1'b1;
          r_cnt   <= '0;
          r_state <= HOLD;
        end
      end else if (!req[owner]) begin
        gnt     <= '0;
        r_state <= IDLE;
      end else if (r_cnt == CW'(TIMEOUT-1)) begin
        gnt     <= '0;
        err     <= 1'b1;
        r_state <= IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dreg_share_arbiter.sv
// tb_dreg_share_arbiter: directed scenario tasks for the shared-register arbiter
module tb_dreg_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = {8'h3C, 8'hA5, 8'h5A, 8'h11};
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;
  logic        err;
  int errors = 0;
  int checks = 0;
  logic [7:0] dat [4] = '{8'h11, 8'h5A, 8'hA5, 8'h3C};

  dreg_share_arbiter #(.WIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({gnt, q, q_valid, owner, err} !== 16'h0)
      begin errors++; $display("FAIL reset_state got gnt=%b q=%h qv=%b own=%0d err=%b exp all zero", gnt, q, q_valid, owner, err); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({gnt, q, q_valid, owner, err} !== 16'h0)
        begin errors++; $display("FAIL idle_%0d got gnt=%b q=%h qv=%b own=%0d err=%b exp all zero", i, gnt, q, q_valid, owner, err); end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    step();
    checks++;
    if ({gnt, q, q_valid, owner, err} !== {4'b0100, 8'hA5, 1'b1, 2'd2, 1'b0})
      begin errors++; $display("FAIL single_grant got gnt=%b q=%h qv=%b own=%0d err=%b exp 0100 a5 1 2 0", gnt, q, q_valid, owner, err); end
    step();
    step();
    checks++;
    if (gnt !== 4'b0100)
      begin errors++; $display("FAIL single_hold got gnt=%b exp 0100", gnt); end
    req = 4'b0000;
    step();
    checks++;
    if ({gnt, q, q_valid, owner, err} !== {4'b0000, 8'hA5, 1'b1, 2'd2, 1'b0})
      begin errors++; $display("FAIL single_release got gnt=%b q=%h qv=%b own=%0d err=%b exp 0000 a5 1 2 0", gnt, q, q_valid, owner, err); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req = 4'b1111;
    foreach (order[n]) begin
      step();
      checks++;
      if ({gnt, q, owner} !== {4'b0001 << order[n], dat[order[n]], 2'(order[n])})
        begin errors++; $display("FAIL rr_grant_%0d got gnt=%b q=%h own=%0d exp owner %0d q=%h", n, gnt, q, owner, order[n], dat[order[n]]); end
      req[order[n]] = 1'b0;
      step();
      checks++;
      if (gnt !== 4'b0000)
        begin errors++; $display("FAIL rr_gap_%0d got gnt=%b exp 0000", n, gnt); end
      req = 4'b1111;
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 4'b1000;
    step();
    checks++;
    if (owner !== 2'd3)
      begin errors++; $display("FAIL wrap_owner3 got own=%0d exp 3", owner); end
    req = 4'b0000;
    step();
    req = 4'b0011;
    step();
    checks++;
    if ({gnt, q, owner} !== {4'b0001, 8'h11, 2'd0})
      begin errors++; $display("FAIL wrap_first got gnt=%b q=%h own=%0d exp 0001 11 0", gnt, q, owner); end
    req = 4'b0010;
    step();
    step();
    checks++;
    if ({gnt, q, owner} !== {4'b0010, 8'h5A, 2'd1})
      begin errors++; $display("FAIL wrap_second got gnt=%b q=%h own=%0d exp 0010 5a 1", gnt, q, owner); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    int high = 1;
    apply_reset();
    req = 4'b0010;
    step();
    req = 4'b0011;
    checks++;
    if ({gnt, err} !== {4'b0010, 1'b0})
      begin errors++; $display("FAIL to_grant got gnt=%b err=%b exp 0010 0", gnt, err); end
    for (int i = 0; i < 15; i++) begin
      step();
      if (gnt === 4'b0010 && err === 1'b0) high++;
    end
    checks++;
    if (high !== 16)
      begin errors++; $display("FAIL to_hold_cycles got %0d exp 16", high); end
    step();
    checks++;
    if ({gnt, err} !== {4'b0000, 1'b1})
      begin errors++; $display("FAIL to_expire got gnt=%b err=%b exp 0000 1", gnt, err); end
    step();
    checks++;
    if ({gnt, owner, err} !== {4'b0001, 2'd0, 1'b0})
      begin errors++; $display("FAIL to_next got gnt=%b own=%0d err=%b exp 0001 0 0", gnt, owner, err); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    req = 4'b1000;
    step();
    checks++;
    if ({gnt, q, owner} !== {4'b1000, 8'h3C, 2'd3})
      begin errors++; $display("FAIL mid_grant got gnt=%b q=%h own=%0d exp 1000 3c 3", gnt, q, owner); end
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({gnt, q, q_valid, owner, err} !== 16'h0)
      begin errors++; $display("FAIL mid_reset got gnt=%b q=%h qv=%b own=%0d err=%b exp all zero", gnt, q, q_valid, owner, err); end
    rst_n = 1'b1;
    step();
    checks++;
    if ({gnt, q, q_valid, owner} !== {4'b1000, 8'h3C, 1'b1, 2'd3})
      begin errors++; $display("FAIL mid_regrant got gnt=%b q=%h qv=%b own=%0d exp 1000 3c 1 3", gnt, q, q_valid, owner); end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
